// File: rtl/vending_controller_pkg.sv
// Shared definitions for the vending controller slice.
//   state_t      : controller state, encoding is visible on o_state
//   DEF_*        : default parameter values used by the top level
package vending_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COIN     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_RETURN   = 2'd3
  } state_t;

  localparam int DEF_NUM_ITEMS   = 4;
  localparam int DEF_NUM_COINS   = 3;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_STOCK_W     = 4;
  localparam int DEF_STOCK_INIT  = 2;
  localparam int DEF_WAIT_CYCLES = 100;
  localparam int DEF_RETURN_HOLD = 3;

endpackage

// File: rtl/vending_controller_coin_change_picker.sv
// coin_change_picker: combinational largest-coin selector for change return.
//   total       in  CNT_W             credit still to be returned
//   coin_value  in  NUM_COINS*CNT_W   coin k value at [k*CNT_W +: CNT_W]
//   coin_onehot out NUM_COINS         one-hot of the largest coin <= total
//   found       out 1                 a coin fits into total
//   coin_amount out CNT_W             value of the selected coin (0 if none)
module coin_change_picker #(
  parameter int NUM_COINS = 3,
  parameter int CNT_W     = 32
) (
  input  logic [CNT_W-1:0]           total,
  input  logic [NUM_COINS*CNT_W-1:0] coin_value,
  output logic [NUM_COINS-1:0]       coin_onehot,
  output logic                       found,
  output logic [CNT_W-1:0]           coin_amount
);

  // Ascending scan: the last fitting coin is the largest one.
  always_comb begin
    coin_onehot = '0;
    found       = 1'b0;
    coin_amount = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_value[k*CNT_W +: CNT_W] <= total) begin
        coin_onehot    = '0;
        coin_onehot[k] = 1'b1;
        found          = 1'b1;
        coin_amount    = coin_value[k*CNT_W +: CNT_W];
      end
    end
  end

endmodule

// File: rtl/vending_controller.sv
// vending_controller: coin accumulation, item dispensing and change return.
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   i_input_coin        one-cycle one-hot pulse per inserted coin
//   i_select_item       item select pulse, lowest set index wins
//   i_trigger_return    return button level, must be held RETURN_HOLD cycles
//   i_coin_value        static coin values, strictly ascending
//   i_item_price        static item prices, nonzero
//   i_restock           per-item pulse, adds one to stock (saturating)
//   o_available_item    combinational: price <= total and stock != 0
//   o_output_item       registered one-hot dispense pulse (DISPENSE cycle)
//   o_return_coin       registered one-hot returned coin, one per cycle
//   o_coin_total        current credit
//   o_state             current state (IDLE=0, COIN=1, DISPENSE=2, RETURN=3)
//
// Interface semantics: there is no valid/ready handshake. Every input pulse is
// sampled on exactly one rising edge and is never back-pressured; a pulse that
// arrives when it cannot be acted on (coin in RETURN, unaffordable select,
// overflowing coin) is dropped. Outputs are one-cycle registered pulses.
module vending_controller
  import vending_controller_pkg::*;
#(
  parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
  parameter int NUM_COINS   = DEF_NUM_COINS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STOCK_W     = DEF_STOCK_W,
  parameter int STOCK_INIT  = DEF_STOCK_INIT,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int RETURN_HOLD = DEF_RETURN_HOLD
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_COINS-1:0]           i_input_coin,
  input  logic [NUM_ITEMS-1:0]           i_select_item,
  input  logic                           i_trigger_return,
  input  logic [NUM_COINS*CNT_W-1:0]     i_coin_value,
  input  logic [NUM_ITEMS*CNT_W-1:0]     i_item_price,
  input  logic [NUM_ITEMS-1:0]           i_restock,
  output logic [NUM_ITEMS-1:0]           o_available_item,
  output logic [NUM_ITEMS-1:0]           o_output_item,
  output logic [NUM_COINS-1:0]           o_return_coin,
  output logic [CNT_W-1:0]               o_coin_total,
  output logic [1:0]                     o_state
);

  localparam int TMR_W = $clog2(WAIT_CYCLES + 1);
  localparam int RC_W  = $clog2(RETURN_HOLD + 1);
  localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(WAIT_CYCLES);
  localparam logic [RC_W-1:0]    RC_MAX     = RC_W'(RETURN_HOLD);
  localparam logic [RC_W-1:0]    RC_ARM     = RC_W'(RETURN_HOLD - 1);
  localparam logic [STOCK_W-1:0] STOCK_RST  = STOCK_W'(STOCK_INIT);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     total, total_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [RC_W-1:0]      ret_cnt, ret_cnt_nxt;
  logic [STOCK_W-1:0]   stock [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] item_nxt;
  logic [NUM_COINS-1:0] ret_coin_nxt;

  logic                 coin_hit;
  logic [CNT_W-1:0]     coin_amt;
  logic [CNT_W:0]       coin_sum;
  logic [CNT_W-1:0]     credit;
  logic                 sel_hit;
  logic                 sel_ok;
  logic [NUM_ITEMS-1:0] sel_onehot;
  logic [CNT_W-1:0]     sel_price;
  logic                 return_held;
  logic                 dispense_en;
  logic [NUM_COINS-1:0] change_onehot;
  logic                 change_found;
  logic [CNT_W-1:0]     change_amt;

  // ---------------- input decode ----------------
  always_comb begin
    coin_amt = '0;
    for (int k = NUM_COINS - 1; k >= 0; k--) begin
      if (i_input_coin[k]) coin_amt = i_coin_value[k*CNT_W +: CNT_W];
    end
  end

  assign coin_hit = |i_input_coin;
  // One extra bit catches overflow; an overflowing coin leaves credit as is.
  assign coin_sum = {1'b0, total} + {1'b0, coin_amt};
  assign credit   = coin_sum[CNT_W] ? total : coin_sum[CNT_W-1:0];

  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_available_item[i] = (i_item_price[i*CNT_W +: CNT_W] <= total) &&
                            (stock[i] != '0);
    end
  end

  // Descending scan so the lowest set select bit is the one kept.
  always_comb begin
    sel_onehot = '0;
    sel_price  = '0;
    sel_ok     = 1'b0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (i_select_item[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_price     = i_item_price[i*CNT_W +: CNT_W];
        sel_ok        = o_available_item[i];
      end
    end
  end

  assign sel_hit = |i_select_item;
  // The current high sample completes the hold when RETURN_HOLD-1 were seen.
  assign return_held = i_trigger_return && (ret_cnt >= RC_ARM);

  coin_change_picker #(
    .NUM_COINS (NUM_COINS),
    .CNT_W     (CNT_W)
  ) u_picker (
    .total       (total),
    .coin_value  (i_coin_value),
    .coin_onehot (change_onehot),
    .found       (change_found),
    .coin_amount (change_amt)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt   = state;
    dispense_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coin_hit)                           state_nxt = ST_COIN;
        else if (return_held && total != '0)    state_nxt = ST_RETURN;
      end
      ST_COIN: begin
        // Coin beats select beats return/timeout; a rejected select still
        // takes the cycle.
        if (!coin_hit) begin
          if (sel_hit) begin
            if (sel_ok) begin
              dispense_en = 1'b1;
              state_nxt   = ST_DISPENSE;
            end
          end else if (return_held || timer == '0) begin
            state_nxt = ST_RETURN;
          end
        end
      end
      ST_DISPENSE: state_nxt = (credit != '0) ? ST_COIN : ST_IDLE;
      ST_RETURN:   if (total == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs and datapath next values ----------------
  always_comb begin
    total_nxt    = total;
    timer_nxt    = timer;
    ret_cnt_nxt  = ret_cnt;
    item_nxt     = '0;
    ret_coin_nxt = '0;

    if (coin_hit && state != ST_RETURN) total_nxt = credit;

    if (dispense_en) begin
      total_nxt = total - sel_price;
      item_nxt  = sel_onehot;
    end

    // Credit smaller than the smallest coin is forfeited in one step.
    if (state == ST_RETURN && total != '0) begin
      if (change_found) begin
        total_nxt    = total - change_amt;
        ret_coin_nxt = change_onehot;
      end else begin
        total_nxt = '0;
      end
    end

    if ((state != ST_COIN && state_nxt == ST_COIN) ||
        (state == ST_COIN && coin_hit) || dispense_en) begin
      timer_nxt = TMR_LOAD;
    end else if (state == ST_COIN && !sel_hit && state_nxt == ST_COIN) begin
      timer_nxt = timer - 1'b1;
    end

    if ((state != ST_RETURN && state_nxt == ST_RETURN) || !i_trigger_return) begin
      ret_cnt_nxt = '0;
    end else if (ret_cnt != RC_MAX) begin
      ret_cnt_nxt = ret_cnt + 1'b1;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total         <= '0;
      timer         <= TMR_LOAD;
      ret_cnt       <= '0;
      o_output_item <= '0;
      o_return_coin <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_RST;
    end else begin
      total         <= total_nxt;
      timer         <= timer_nxt;
      ret_cnt       <= ret_cnt_nxt;
      o_output_item <= item_nxt;
      o_return_coin <= ret_coin_nxt;
      // Restock and dispense of the same item cancel out.
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (i_restock[i] && !item_nxt[i]) begin
          if (stock[i] != '1) stock[i] <= stock[i] + 1'b1;
        end else if (!i_restock[i] && item_nxt[i]) begin
          stock[i] <= stock[i] - 1'b1;
        end
      end
    end
  end

  assign o_coin_total = total;
  assign o_state      = state;

endmodule
